// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the MIPS core.
//   word_t        - 32-bit machine word
//   fetch_state_t - fetch-stage control state (FETCH, DRAIN, HALTED)
//   fetch_entry_t - one buffered fetch result: instruction plus PC+4 as [31:2]
//   PC_STEP       - sequential PC increment
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t       instr;
    logic [31:2] npc;
  } fetch_entry_t;

  localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: 2-entry FIFO between instruction memory and IF/ID.
// Slot 0 is always the head; a pop shifts slot 1 into slot 0.
// Ports:
//   clk, rst            clock / asynchronous active-high reset
//   push, push_instr,
//   push_npc            write a new entry at the tail
//   pop                 drop the head entry (ignored when empty)
//   flush               empty the FIFO; overrides push and pop
//   count               number of valid entries (0..2)
//   head_instr, head_npc  contents of the head slot
module fetch_skid_buffer
  import cpu_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_instr,
  input  logic [29:0] push_npc,
  output logic [1:0]  count,
  output logic [31:0] head_instr,
  output logic [29:0] head_npc
);

  fetch_entry_t entry_reg  [2];
  fetch_entry_t entry_next [2];
  fetch_entry_t new_entry;
  logic [1:0]   count_reg;
  logic [1:0]   count_next;
  logic         pop_ok;
  logic         push_ok;
  logic [1:0]   wr_idx;

  assign new_entry = '{instr: push_instr, npc: push_npc};

  // A full buffer can still accept a push when the head leaves on the same edge.
  assign pop_ok  = pop && (count_reg != 2'd0);
  assign push_ok = push && ((count_reg != 2'd2) || pop_ok);
  assign wr_idx  = count_reg - {1'b0, pop_ok};

  always_comb begin
    count_next = count_reg + {1'b0, push_ok} - {1'b0, pop_ok};
    if (flush) count_next = 2'd0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      always_comb begin
        entry_next[gi] = entry_reg[gi];
        if (pop_ok && gi == 0) entry_next[gi] = entry_reg[1];
        if (push_ok && wr_idx == 2'(gi)) entry_next[gi] = new_entry;
      end

      // Contents need no clearing on flush: count alone defines validity.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) entry_reg[gi] <= '0;
        else if (!flush) entry_reg[gi] <= entry_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_reg <= 2'd0;
    else count_reg <= count_next;
  end

  assign count      = count_reg;
  assign head_instr = entry_reg[0].instr;
  assign head_npc   = entry_reg[0].npc;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, issues instruction-memory reads, buffers up to two returned
// instructions ahead of IF/ID and handles branch/jump redirects and halt.
// Ports:
//   CLK, RST                    clock / asynchronous active-high reset
//   ihit, imemload              memory response strobe and data
//   imemREN, imemaddr           memory read request and address
//   stall                       IF/ID cannot accept the head this cycle
//   redirect, redirect_pc       taken branch/jump pulse and target
//   halt                        core halt level from MEM/WB
//   instr_o, npc_o, instr_valid head of buffer towards IF/ID
//   pc_o                        current fetch PC
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr_o,
  output logic [29:0] npc_o,
  output logic        instr_valid,
  output logic [31:0] pc_o
);

  fetch_state_t state_reg, state_next;
  word_t        pc_reg, pc_next;
  word_t        target_reg, target_next;
  word_t        pc_plus4;
  word_t        redirect_tgt;
  logic         req;
  logic         push;
  logic         pop;
  logic         flush;
  logic [1:0]   count;

  assign pc_plus4     = pc_reg + PC_STEP;
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= FETCH;
      pc_reg     <= PC_INIT;
      target_reg <= PC_INIT;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      target_reg <= target_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    target_next = target_reg;
    push        = 1'b0;
    flush       = 1'b0;
    req         = 1'b0;

    case (state_reg)
      FETCH: begin
        // count only grows on ihit, so a request once raised stays raised.
        req = (count != 2'd2);
        if (redirect) begin
          flush = 1'b1;
          if (ihit || !req) begin
            pc_next = redirect_tgt;
          end else begin
            // The outstanding read must complete before a new address is
            // presented; park the target until it does.
            target_next = redirect_tgt;
            state_next  = DRAIN;
          end
        end else if (ihit) begin
          push    = 1'b1;
          pc_next = pc_plus4;
        end
      end
      DRAIN: begin
        req = 1'b1;
        if (redirect && ihit) begin
          pc_next    = redirect_tgt;
          state_next = FETCH;
        end else if (redirect) begin
          target_next = redirect_tgt;
        end else if (ihit) begin
          pc_next    = target_reg;
          state_next = FETCH;
        end
      end
      HALTED: begin
        req = 1'b0;
      end
      default: begin
        state_next = FETCH;
      end
    endcase

    // Halt overrides everything, abandoning any outstanding read.
    if (halt) begin
      state_next  = HALTED;
      flush       = 1'b1;
      push        = 1'b0;
      pc_next     = pc_reg;
      target_next = target_reg;
    end
  end

  assign pop = instr_valid && !stall;

  fetch_skid_buffer u_buf (
    .clk        (CLK),
    .rst        (RST),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_instr (imemload),
    .push_npc   (pc_plus4[31:2]),
    .count      (count),
    .head_instr (instr_o),
    .head_npc   (npc_o)
  );

  assign instr_valid = (count != 2'd0);

  // Reset kills the request combinationally, not just at the next edge.
  assign imemREN  = req && !RST;
  assign imemaddr = RST ? 32'h0 : pc_reg;
  assign pc_o     = pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit against a
// queue-based reference model of the fetch stage.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic [31:0] instr_o;
  logic [29:0] npc_o;
  logic        instr_valid;
  logic [31:0] pc_o;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  fetch_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr_o(instr_o), .npc_o(npc_o), .instr_valid(instr_valid), .pc_o(pc_o)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] npc;
  } ent_t;

  // Reference model: 0 = fetching, 1 = waiting out an old read, 2 = halted.
  ent_t        m_q[$];
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_target;
  int          mem_wait;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic exp_ren();
    return (m_mode == 0 && m_q.size() < 2) || m_mode == 1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_mode   = 0;
    m_pc     = PC_INIT;
    m_target = PC_INIT;
  endtask

  task automatic model_step(input logic h, input logic s, input logic r,
                            input logic [31:0] rp, input logic hl);
    logic [31:0] t;
    ent_t        e;
    t = rp & 32'hFFFF_FFFC;
    if (hl) begin
      m_mode = 2;
      m_q.delete();
    end else if (m_mode == 0) begin
      if (r) begin
        if (h || m_q.size() == 2) m_pc = t;
        else begin
          m_target = t;
          m_mode   = 1;
        end
        m_q.delete();
      end else begin
        if (m_q.size() != 0 && !s) void'(m_q.pop_front());
        if (h) begin
          e.instr = mem_data(m_pc);
          e.npc   = m_pc + 32'd4;
          m_q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end else if (m_mode == 1) begin
      if (r && h) begin
        m_pc   = t;
        m_mode = 0;
      end else if (r) begin
        m_target = t;
      end else if (h) begin
        m_pc   = m_target;
        m_mode = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("imemREN", 32'(imemREN), 32'(exp_ren()));
    check("imemaddr", imemaddr, m_pc);
    check("pc_o", pc_o, m_pc);
    check("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("instr_o", instr_o, m_q[0].instr);
      check("npc_o", 32'(npc_o), 32'(m_q[0].npc[31:2]));
    end
  endtask

  // One clock: drive inputs, step the model at the edge, then sample.
  // Memory only answers while a read is being requested.
  task automatic apply(input logic h, input logic s, input logic r,
                       input logic [31:0] rp, input logic hl);
    logic h_eff;
    h_eff       = h && exp_ren();
    ihit        = h_eff;
    imemload    = h_eff ? mem_data(m_pc) : $urandom;
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    halt        = hl;
    @(posedge CLK);
    model_step(h_eff, s, r, rp, hl);
    #1;
    check_outputs();
  endtask

  function automatic logic mem_hit();
    if (!exp_ren()) return 1'b0;
    if (mem_wait == 0) begin
      mem_wait = $urandom_range(0, 3);
      return 1'b1;
    end
    mem_wait--;
    return 1'b0;
  endfunction

  task automatic random_phase(input int cycles);
    logic        h;
    logic        r;
    logic [31:0] rp;
    for (int i = 0; i < cycles; i++) begin
      h  = mem_hit();
      r  = ($urandom_range(0, 11) == 0);
      rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF) : $urandom & 32'h0000_FFFF;
      apply(h, $urandom_range(0, 2) == 0, r, rp, 1'b0);
    end
  endtask

  task automatic check_reset_state();
    check("rst_imemREN", 32'(imemREN), 32'h0);
    check("rst_imemaddr", imemaddr, 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_pc_o", pc_o, PC_INIT);
    check("rst_instr_o", instr_o, 32'h0);
    check("rst_npc_o", 32'(npc_o), 32'h0);
  endtask

  initial begin
    model_reset();
    mem_wait = 0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_state();
    @(negedge CLK);
    RST = 1'b0;

    // Sequential fetch, memory answering one cycle after each request.
    for (int i = 0; i < 8; i++) apply(i[0], 1'b0, 1'b0, '0, 1'b0);

    // Stall with memory answering every cycle: buffer fills, request drops.
    for (int i = 0; i < 4; i++) apply(1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) apply(i[0], 1'b0, 1'b0, '0, 1'b0);

    // Redirect to 0x100 against a slow outstanding read.
    apply(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0);
    apply(1'b0, 1'b0, 1'b0, '0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, '0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) apply(i[0], 1'b0, 1'b0, '0, 1'b0);

    // Redirect to 0x200 coinciding with ihit; low target bits ignored.
    apply(1'b1, 1'b0, 1'b1, 32'h0000_0203, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // PC wrap-around at 0xFFFF_FFFC.
    apply(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    apply(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b0, 1'b0, '0, 1'b0);

    random_phase(1500);

    // Halt together with redirect, then stay halted regardless of inputs.
    apply(1'b1, 1'b0, 1'b1, 32'h0000_0400, 1'b1);
    for (int i = 0; i < 6; i++)
      apply(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1);

    // Reset pulse: outputs drop asynchronously, fetch restarts at PC_INIT.
    #1 RST = 1'b1;
    #1 check_reset_state();
    model_reset();
    mem_wait = 0;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) apply(i[0], 1'b0, 1'b0, '0, 1'b0);

    random_phase(600);

    // Reset in the middle of an outstanding read.
    apply(1'b0, 1'b0, 1'b0, '0, 1'b0);
    #2 RST = 1'b1;
    #1 check("mid_rst_imemREN", 32'(imemREN), 32'h0);
    model_reset();
    mem_wait = 0;
    @(negedge CLK);
    RST = 1'b0;
    random_phase(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues instruction-memory read requests.
- Buffers up to two fetched instructions so that a downstream stall never drops an instruction already returned by memory.
- Handles branch/jump redirects, including redirects that arrive while a memory request is outstanding, and the halt condition.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
ihit  in  1  instruction memory has returned data this cycle
imemload  in  32  instruction data, valid when ihit=1
imemREN  out  1  instruction read request
imemaddr  out  32  instruction read address
stall  in  1  IF/ID cannot accept this cycle (hazard unit)
redirect  in  1  single-cycle pulse: branch/jump resolved taken
redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
halt  in  1  level from MEM/WB halt_o
instr_o  out  32  head instruction, drives IF/ID instr_i
npc_o  out  30  head PC+4 as [31:2], drives IF/ID npc_i
instr_valid  out  1  head entry valid, drives IF/ID EN
pc_o  out  32  current fetch PC (debug/trace)

Behaviour:
- Asynchronous reset (RST=1): pc=PC_INIT, state=FETCH, count=0, instr_o=0, npc_o=0, instr_valid=0, pc_o=PC_INIT.
- While RST is high, imemREN=0 and imemaddr=0.
- Buffer:
  - 2-entry FIFO; each entry is {instr, npc[31:2]}.
  - The head drives instr_o/npc_o. instr_valid = (count!=0).
  - Consume at a clock edge where instr_valid=1 and stall=0.
  - Push at a clock edge where state=FETCH, ihit=1, redirect=0 and halt=0. The pushed entry is {imemload, pc+4}.
  - Push and consume in the same edge: count is unchanged and the tail moves to the head.
- Request issue:
  - imemREN = (state==FETCH && count<2) || state==DRAIN.
  - imemaddr = pc in FETCH, and the latched old address in DRAIN.
  - Once imemREN rises, imemaddr holds constant until ihit. This holds because count only grows on ihit, so count<2 stays true for the whole request.
- PC update: on a push edge, pc <= pc+4 using 32-bit wrap-around (0xFFFF_FFFC -> 0x0000_0000). Latency is 1 edge after ihit: instr_valid=1 the cycle after ihit when count was 0.
- States: FETCH, DRAIN, HALTED.
- FETCH:
  - redirect=1 with ihit=1, or with no outstanding request (count==2): flush the buffer (count<=0), pc<=redirect_pc, stay in FETCH. The same-cycle imemload is dropped.
  - redirect=1 with a request outstanding and ihit=0: flush the buffer, latch target<=redirect_pc, go to DRAIN. imemaddr stays at the old pc.
- DRAIN:
  - imemREN=1 at the old address until ihit.
  - On ihit, the data is discarded, pc<=target, and the state goes to FETCH.
  - A further redirect in DRAIN overwrites target and stays in DRAIN. If that redirect coincides with ihit, go to FETCH with the new redirect_pc.
- HALTED:
  - Entered from any state on a clock edge with halt=1; halt has priority over redirect and ihit.
  - On entry: count<=0 and imemREN=0. An outstanding request is abandoned; this is permitted only because the core is halting.
  - Exit only via RST.
- stall with count==0 has no effect. stall never blocks a memory response because the second entry absorbs it.
- RST mid-request: the request is dropped immediately (imemREN=0 asynchronously); after release, fetch restarts at PC_INIT.

Decomposition:
- Add fetch_state_t (FETCH, DRAIN, HALTED) and a fetch_entry_t struct {word_t instr; logic [31:2] npc;} to cpu_types_pkg. Reuse word_t there.
- One sub-module, fetch_skid_buffer: 2-entry FIFO with push/pop/flush, count output, and head output.
- fetch_unit holds the PC, state machine, and request logic.

Test Plan:
- Reset, ihit returns 1 cycle after each request, stall=0 -> imemaddr sequence 0x0, 0x4, 0x8. instr_valid high from the cycle after the first ihit. npc_o = 0x1, 0x2, 0x3 (as [31:2]).
- stall held for 4 cycles with ihit every cycle -> count saturates at 2 and imemREN drops. On stall release the instructions from 0x4 and 0x8 emerge in order with none lost or duplicated, and fetch resumes at 0xC.
- redirect=1, redirect_pc=0x100 while imemaddr=0x20 and ihit=0 (memory latency 3) -> imemaddr stays 0x20 until ihit. That data is discarded. The next request is 0x100 and instr_valid=0 throughout DRAIN.
- redirect to 0x200 coincident with ihit at 0x40 -> the 0x40 data is not pushed, the buffer is flushed, and the next imemaddr is 0x200.
- pc=0xFFFF_FFFC with ihit -> npc_o=0 and the next imemaddr is 0x0.
- halt=1 together with redirect=1 -> HALTED, imemREN=0 and instr_valid=0 permanently. RST pulse -> imemaddr=PC_INIT with fetch resumed.
